pulse_stretch: RTL and testbench
================================

// Module: pulse_stretch
// PURPOSE
//   Output-side counterpart of the button debouncer: the debouncer turns a long physical
//   level into a one-cycle pulse, and this block turns one-cycle event pulses back into
//   human-visible levels for LEDs and indicators.
//   - Each accepted pulse produces one high window of HOLD_TICKS slow ticks, followed by a
//     low gap of GAP_TICKS ticks.
//   - Bursts are queued in a saturating pending counter, so every event stays distinct.
//   - Sits between the debounce/edge logic and the LED drivers; the slow timebase arrives
//     as a tick enable in the clk domain.
// PARAMETERS
//   HOLD_TICKS  4  slow ticks out stays high per event (>=1)
//   GAP_TICKS   2  slow ticks out stays low between events (>=1)
//   PEND_W      4  pending-counter width; queue depth = 2**PEND_W-1
// PORTS
//   clk       in   1       system clock; all logic on posedge
//   rst_n     in   1       synchronous active-low reset
//   tick      in   1       one-cycle slow-timebase enable from clock divider
//   pulse_in  in   1       event pulse; each high cycle counts as one event
//   out       out  1       stretched output (registered)
//   busy      out  1       1 when state != IDLE (registered)
//   pending   out  PEND_W  events queued, not yet started
//   overflow  out  1       sticky: an event was dropped at saturation
// BEHAVIOUR
//   Reset (rst_n=0 at posedge):
//   - state=IDLE, cnt=0, pending=0, out=0, busy=0, overflow=0.
//   - Reset overrides any in-progress window and all queued events.
//   FSM states: IDLE, HOLD, GAP. out=1 iff state==HOLD. busy=1 iff state!=IDLE.
//   IDLE:
//   - If pending!=0 or pulse_in=1: next state=HOLD, cnt=0, one event consumed.
//   - tick is ignored.
//   - Latency: pulse_in high at edge N (IDLE, pending=0) -> out=1 after edge N.
//   HOLD:
//   - On tick: if cnt==HOLD_TICKS-1, go to GAP with cnt=0; else cnt+=1.
//   GAP:
//   - On tick: if cnt==GAP_TICKS-1, go to IDLE with cnt=0; else cnt+=1.
//   - IDLE re-launches on the following edge if pending!=0.
//   Window length: first tick period is partial (tick phase not aligned).
//   - High time is HOLD_TICKS ticks counted, i.e. >HOLD_TICKS-1 and <=HOLD_TICKS periods.
//   - GAP is bounded the same way.
//   Pending update per edge:
//   - pending_next = pending + pulse_in - consume.
//   - consume=1 only on the IDLE->HOLD transition.
//   - Simultaneous pulse_in and consume: pending unchanged, no overflow.
//   - pulse_in=1, consume=0, pending==2**PEND_W-1: pending holds at max, overflow<=1.
//   - overflow stays set until reset.
//   - pulse_in is accepted in every state, including HOLD and GAP.
//   cnt width: $clog2 of max(HOLD_TICKS, GAP_TICKS) plus 1 bit. No combinational
//   path from inputs to outputs.
// TESTING  (HOLD_TICKS=4, GAP_TICKS=2, PEND_W=2, tick every 10 clk)
//   Single event:
//   - Stimulus: pulse_in 1 cycle at cycle 5 from IDLE.
//   - Response: out=1 from cycle 6 for 4 ticks; then 0 for 2 ticks; busy falls after GAP;
//     pending stays 0.
//   Burst of 3:
//   - Stimulus: pulse_in on 3 consecutive cycles.
//   - Response: pending goes 0,1,2; exactly 3 high windows, each separated by a 2-tick
//     gap; pending reaches 0.
//   Saturation:
//   - Stimulus: 5 pulses during the first HOLD.
//   - Response: pending saturates at 3, overflow=1, exactly 4 windows total, overflow
//     still 1 at the end.
//   Simultaneous:
//   - Stimulus: pulse_in at the edge IDLE->HOLD with pending=1.
//   - Response: pending stays 1, no overflow.
//   Reset mid-HOLD:
//   - Stimulus: rst_n=0 for 1 cycle while pending=2.
//   - Response: next edge out=0, busy=0, pending=0, overflow=0; a later pulse restarts
//     normally.
//   Ticks in IDLE:
//   - Stimulus: 20 ticks with no pulse.
//   - Response: out=0, busy=0, pending=0 throughout.

Source files
------------

// File: rtl/pulse_stretch.sv
// pulse_stretch: stretches one-cycle event pulses into tick-timed high windows separated by low gaps.
// Events arriving while a window runs are queued in a saturating pending counter.
module pulse_stretch #(
  parameter int HOLD_TICKS = 4,
  parameter int GAP_TICKS  = 2,
  parameter int PEND_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              pulse_in,
  output logic              out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);
  localparam int MAXT = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
  localparam int CW   = $clog2(MAXT) + 1;
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
  state_t            r_state, w_state_nx;
  logic [CW-1:0]     r_cnt, w_cnt_nx;
  logic [PEND_W-1:0] r_pend, w_pend_nx;
  logic              r_ovf, w_ovf_nx, r_out, r_busy;
  logic              w_consume, w_full, w_inc, w_dec;
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_consume  = 1'b0;
    case (r_state)
      IDLE: if (r_pend != '0 || pulse_in) begin
        w_state_nx = HOLD;
        w_cnt_nx   = '0;
        w_consume  = 1'b1;
      end
      HOLD: if (tick) begin
        w_state_nx = (r_cnt == CW'(HOLD_TICKS - 1)) ? GAP : HOLD;
        w_cnt_nx   = (r_cnt == CW'(HOLD_TICKS - 1)) ? '0 : r_cnt + 1'b1;
      end
      GAP: if (tick) begin
        w_state_nx = (r_cnt == CW'(GAP_TICKS - 1)) ? IDLE : GAP;
        w_cnt_nx   = (r_cnt == CW'(GAP_TICKS - 1)) ? '0 : r_cnt + 1'b1;
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end
  // an arriving pulse and a launch in the same cycle cancel out
  assign w_full    = &r_pend;
  assign w_inc     = pulse_in & ~w_consume;
  assign w_dec     = ~pulse_in & w_consume;
  assign w_pend_nx = w_inc ? (w_full ? r_pend : r_pend + 1'b1) : w_dec ? r_pend - 1'b1 : r_pend;
  assign w_ovf_nx  = r_ovf | (w_inc & w_full);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_ovf   <= 1'b0;
      r_out   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_pend  <= w_pend_nx;
      r_ovf   <= w_ovf_nx;
      r_out   <= (w_state_nx == HOLD);
      r_busy  <= (w_state_nx != IDLE);
    end
  end
  assign out      = r_out;
  assign busy     = r_busy;
  assign pending  = r_pend;
  assign overflow = r_ovf;
endmodule

// File: tb/tb_pulse_stretch.sv
// tb_pulse_stretch: table-driven vectors plus tick-timed sequences for bursts, saturation and reset.
module tb_pulse_stretch;
  logic       clk = 1'b0;
  logic       rst_n, tick, pulse_in;
  logic       out, busy, overflow;
  logic [1:0] pending;
  int         n_chk = 0, n_fail = 0, tcnt = 0;
  int         wins, hmin, hmax, gmin, gmax;
  typedef struct {
    logic       rst_n, tick, pulse, out, busy;
    logic [1:0] pend;
    logic       ovf;
  } vec_t;
  vec_t v[16];
  pulse_stretch #(.HOLD_TICKS(4), .GAP_TICKS(2), .PEND_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .pulse_in(pulse_in),
    .out(out), .busy(busy), .pending(pending), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", n, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic t, input logic p);
    rst_n = r;
    tick = t;
    pulse_in = p;
    @(posedge clk);
    #1;
  endtask
  task automatic astep(input logic p);
    step(1'b1, tcnt == 9, p);
    tcnt = (tcnt + 1) % 10;
  endtask
  task automatic drain(output int w, output int h0, output int h1, output int g0, output int g1);
    int run;
    logic prev, skip;
    w = out ? 1 : 0;
    h0 = 1000; h1 = 0; g0 = 1000; g1 = 0;
    prev = out; skip = out; run = 1;
    for (int i = 0; i < 2000; i++) begin
      astep(1'b0);
      if (out !== prev) begin
        if (prev) begin
          if (!skip) begin
            h0 = (run < h0) ? run : h0;
            h1 = (run > h1) ? run : h1;
          end
          skip = 1'b0;
        end else if (w > 0) begin
          g0 = (run < g0) ? run : g0;
          g1 = (run > g1) ? run : g1;
        end
        if (out) w++;
        run = 1;
        prev = out;
      end else run++;
      if (!busy && pending == 2'd0) break;
    end
    chk("drain_idle", {busy, pending}, 3'b000);
  endtask
  initial begin
    //        rst tick pls  out busy pend ovf
    v[0]  = '{0, 0, 0, 0, 0, 2'd0, 0};
    v[1]  = '{1, 1, 0, 0, 0, 2'd0, 0};
    v[2]  = '{1, 0, 1, 1, 1, 2'd0, 0};
    v[3]  = '{1, 0, 1, 1, 1, 2'd1, 0};
    v[4]  = '{1, 0, 1, 1, 1, 2'd2, 0};
    v[5]  = '{1, 0, 1, 1, 1, 2'd3, 0};
    v[6]  = '{1, 0, 1, 1, 1, 2'd3, 1};
    v[7]  = '{1, 1, 0, 1, 1, 2'd3, 1};
    v[8]  = '{1, 1, 0, 1, 1, 2'd3, 1};
    v[9]  = '{1, 1, 0, 1, 1, 2'd3, 1};
    v[10] = '{1, 1, 0, 0, 1, 2'd3, 1};
    v[11] = '{1, 1, 0, 0, 1, 2'd3, 1};
    v[12] = '{1, 1, 0, 0, 0, 2'd3, 1};
    v[13] = '{1, 0, 0, 1, 1, 2'd2, 1};
    v[14] = '{0, 0, 1, 0, 0, 2'd0, 0};
    v[15] = '{1, 0, 1, 1, 1, 2'd0, 0};
    rst_n = 1'b0; tick = 1'b0; pulse_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step(v[i].rst_n, v[i].tick, v[i].pulse);
      chk($sformatf("vec%0d_out", i), out, v[i].out);
      chk($sformatf("vec%0d_busy", i), busy, v[i].busy);
      chk($sformatf("vec%0d_pend", i), pending, v[i].pend);
      chk($sformatf("vec%0d_ovf", i), overflow, v[i].ovf);
    end
    drain(wins, hmin, hmax, gmin, gmax);
    // burst of three: pending counts 0,1,2 then three windows with exact 2-tick gaps
    astep(1'b1); chk("burst_p0", pending, 0); chk("burst_out", out, 1);
    astep(1'b1); chk("burst_p1", pending, 1);
    astep(1'b1); chk("burst_p2", pending, 2);
    drain(wins, hmin, hmax, gmin, gmax);
    chk("burst_wins", wins, 3);
    chk("burst_hmin", hmin >= 31, 1);
    chk("burst_hmax", hmax <= 40, 1);
    chk("burst_gmin", gmin, 21);
    chk("burst_gmax", gmax, 21);
    // saturation: five extra pulses during the first window
    astep(1'b1);
    for (int i = 0; i < 5; i++) astep(1'b1);
    chk("sat_pend", pending, 3);
    chk("sat_ovf", overflow, 1);
    drain(wins, hmin, hmax, gmin, gmax);
    chk("sat_wins", wins, 4);
    chk("sat_ovf_sticky", overflow, 1);
    step(1'b0, 1'b0, 1'b0);
    chk("sat_rst_ovf", overflow, 0);
    // simultaneous pulse and launch
    astep(1'b1); astep(1'b1);
    chk("sim_pend1", pending, 1);
    for (int i = 0; i < 200 && busy; i++) astep(1'b0);
    chk("sim_idle", {busy, pending}, 3'b001);
    astep(1'b1);
    chk("sim_out", out, 1);
    chk("sim_pend", pending, 1);
    chk("sim_ovf", overflow, 0);
    drain(wins, hmin, hmax, gmin, gmax);
    chk("sim_wins", wins, 2);
    // reset in the middle of a window
    astep(1'b1); astep(1'b1); astep(1'b1);
    chk("rst_pre_pend", pending, 2);
    step(1'b0, 1'b0, 1'b0);
    chk("rst_state", {out, busy, pending, overflow}, 5'b00000);
    astep(1'b1);
    chk("rst_restart", {out, busy, pending}, 4'b1100);
    drain(wins, hmin, hmax, gmin, gmax);
    chk("rst_wins", wins, 1);
    for (int i = 0; i < 200; i++) begin
      astep(1'b0);
      chk("idle_ticks", {out, busy, pending, overflow}, 5'b00000);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
